// File: rtl/calc_pkg.sv
// Shared key codes, FSM/op encodings and display constants for the keypad calculator.
// Divide support is compiled in only when CALC_DIV_EN is defined.
package calc_pkg;

  localparam logic [7:0] KEY_CLEAR = 8'hC0;
  localparam logic [7:0] KEY_EQU   = 8'hE0;
  localparam logic [7:0] KEY_ADD   = 8'hF0;
  localparam logic [7:0] KEY_SUB   = 8'hF1;
  localparam logic [7:0] KEY_MUL   = 8'hF2;
  localparam logic [7:0] KEY_DIV   = 8'hF3;

  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [3:0] ERR_DIG = 4'hE;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPA    = 3'd1,
    OP     = 3'd2,
    OPB    = 3'd3,
    CALC   = 3'd4,
    CONV   = 3'd5,
    RESULT = 3'd6
  } state_t;

  // Low two bits of the operator key codes map straight onto this enum.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  function automatic logic key_is_op(input logic [7:0] k);
`ifdef CALC_DIV_EN
    return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL) || (k == KEY_DIV);
`else
    return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
`endif
  endfunction

  function automatic op_t key_to_op(input logic [7:0] k);
    return op_t'(k[1:0]);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle, W cycles per start.
// done is high during the final shift cycle, so bcd is valid from the following cycle.
module bin2bcd_seq #(
  parameter int W = 14,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   sh;
  logic [CW-1:0]  cnt;
  logic [4*D-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < D; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (start) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= CW'(W);
    end else if (busy) begin
      {bcd, sh} <= {adj[4*D-2:0], sh, 1'b0};
      cnt       <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// Keypad calculator entry controller: operand/operator entry FSM, arithmetic and BCD display.
// Define CALC_DIV_EN to add the integer divide key (8'hF3) and divide-by-zero error display.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int OPW    = $clog2(10**DIGITS),
  parameter int RW     = 2*OPW,
  parameter int RD     = 2*DIGITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      key_code,
  input  logic            key_valid,
  output logic [4*RD-1:0] disp_bcd,
  output logic [2:0]      disp_stage,
  output logic            neg,
  output logic            err,
  output logic            busy
);

  localparam int              ENW    = 4*DIGITS;
  localparam logic [RW-1:0]   LIMIT  = RW'(10**DIGITS);
  localparam logic [OPW-1:0]  TEN    = OPW'(10);
  localparam logic [2:0]      MAXCNT = 3'(DIGITS);

  state_t          state;
  op_t             op;
  logic [OPW-1:0]  a, b;
  logic [2:0]      cnt;
  logic [ENW-1:0]  ent;
  logic [RW-1:0]   r;
  logic            dz;

  logic            is_dig, is_op, is_equ, is_clr;
  logic [OPW-1:0]  dig_w, acc_nxt;
  logic [ENW-1:0]  ent_nxt;
  logic [RW-1:0]   r_calc, a_w, b_w;
  logic            neg_calc, dz_calc;
  logic            cv_start, cv_busy, cv_done;
  logic [4*RD-1:0] cv_bcd;
  logic            seen;

  assign is_dig  = key_valid && (key_code <= 8'h09);
  assign is_op   = key_valid && key_is_op(key_code);
  assign is_equ  = key_valid && (key_code == KEY_EQU);
  assign is_clr  = key_valid && (key_code == KEY_CLEAR);
  assign dig_w   = OPW'(key_code[3:0]);
  assign acc_nxt = ((state == OPB) ? b : a) * TEN + dig_w;
  assign ent_nxt = (ent << 4) | ENW'(key_code[3:0]);

  // Magnitude result; subtraction with A<B flips operands and flags neg.
  always_comb begin
    r_calc   = '0;
    neg_calc = 1'b0;
    dz_calc  = 1'b0;
    a_w      = RW'(a);
    b_w      = RW'(b);
    case (op)
      OP_ADD: r_calc = a_w + b_w;
      OP_SUB: begin
        if (a < b) begin
          r_calc   = b_w - a_w;
          neg_calc = 1'b1;
        end else begin
          r_calc = a_w - b_w;
        end
      end
      OP_MUL: r_calc = a_w * b_w;
      default: begin
`ifdef CALC_DIV_EN
        if (b == '0) dz_calc = 1'b1;
        else         r_calc  = RW'(a / b);
`endif
      end
    endcase
  end

  assign cv_start = (state == CALC) && !is_clr && !dz_calc;

  bin2bcd_seq #(.W(RW), .D(RD)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (cv_start),
    .bin   (r_calc),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= OP_ADD;
      a     <= '0;
      b     <= '0;
      cnt   <= '0;
      ent   <= '0;
      r     <= '0;
      dz    <= 1'b0;
      neg   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else if (state == CONV) begin
      // Keys are dropped here; leave only when the converter finishes.
      if (cv_done || !cv_busy) begin
        state <= RESULT;
        busy  <= 1'b0;
      end
    end else if (is_clr) begin
      state <= IDLE;
      op    <= OP_ADD;
      a     <= '0;
      b     <= '0;
      cnt   <= '0;
      ent   <= '0;
      r     <= '0;
      dz    <= 1'b0;
      neg   <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE, RESULT: begin
          if (is_dig) begin
            state <= OPA;
            a     <= dig_w;
            b     <= '0;
            cnt   <= 3'd1;
            ent   <= ENW'(key_code[3:0]);
            neg   <= 1'b0;
            err   <= 1'b0;
            dz    <= 1'b0;
          end else if (state == RESULT && is_op) begin
            // Chain the result as the next A only if it is a valid operand.
            if (!neg && !dz && (r < LIMIT)) begin
              a     <= r[OPW-1:0];
              op    <= key_to_op(key_code);
              state <= OP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        OPA: begin
          if (is_dig) begin
            if (cnt < MAXCNT) begin
              a   <= acc_nxt;
              cnt <= cnt + 3'd1;
              ent <= ent_nxt;
            end
          end else if (is_op) begin
            op    <= key_to_op(key_code);
            state <= OP;
          end
        end
        OP: begin
          if (is_dig) begin
            b     <= dig_w;
            cnt   <= 3'd1;
            ent   <= ENW'(key_code[3:0]);
            state <= OPB;
          end else if (is_op) begin
            op <= key_to_op(key_code);
          end
        end
        OPB: begin
          if (is_dig) begin
            if (cnt < MAXCNT) begin
              b   <= acc_nxt;
              cnt <= cnt + 3'd1;
              ent <= ent_nxt;
            end
          end else if (is_equ) begin
            state <= CALC;
          end
        end
        CALC: begin
          r   <= r_calc;
          neg <= neg_calc;
          err <= dz_calc;
          dz  <= dz_calc;
          if (dz_calc) begin
            state <= RESULT;
          end else begin
            state <= CONV;
            busy  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    disp_bcd = {RD{BLANK}};
    seen     = 1'b0;
    case (state)
      OPA, OPB, CALC, CONV: begin
        for (int i = 0; i < DIGITS; i++)
          if (3'(i) < cnt) disp_bcd[4*i +: 4] = ent[4*i +: 4];
      end
      RESULT: begin
        if (dz) begin
          disp_bcd = {RD{ERR_DIG}};
        end else begin
          // Blank leading zeros; digit 0 is always shown.
          for (int i = RD - 1; i >= 0; i--) begin
            if ((cv_bcd[4*i +: 4] != 4'd0) || (i == 0)) seen = 1'b1;
            if (seen) disp_bcd[4*i +: 4] = cv_bcd[4*i +: 4];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    disp_stage = 3'd0;
    case (state)
      OPA:                  disp_stage = 3'd1;
      OP:                   disp_stage = 3'd2;
      OPB, CALC, CONV:      disp_stage = 3'd3;
      RESULT:               disp_stage = 3'd4;
      default:              disp_stage = 3'd0;
    endcase
  end

endmodule
